// File: rtl/io_input_ctrl.sv
// Sequencer between the SUBLEQ CPU input port and the io_input byte source: four-phase
// req/ack fetch FSM, small byte FIFO, EOF handling. Define IO_INPUT_PREFETCH_EN to fill ahead of demand.
module io_input_ctrl #(
  parameter int DEPTH     = 4,
  parameter int WORD_SIZE = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_rd_req,
  output logic                     cpu_rd_done,
  output logic [WORD_SIZE-1:0]     cpu_rd_data,
  output logic                     io_req,
  input  logic                     io_ack,
  input  logic                     io_eof,
  input  logic [WORD_SIZE-1:0]     io_data,
  output logic                     eof_seen,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, REQ, REL, DONE} state_t;

  state_t      state;
  logic        ack_meta;
  logic        ack_s;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];

  logic empty;
  logic full;
  logic fetch_want;
  logic push;
  logic serve;
  logic pop;
  logic unused_hi;

  assign unused_hi = ^io_data[WORD_SIZE-1:8];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;

`ifdef IO_INPUT_PREFETCH_EN
  assign fetch_want = !full && !eof_seen;
`else
  // Only fetch on demand; the done cycle is excluded so a finished read cannot retrigger.
  assign fetch_want = cpu_rd_req && !cpu_rd_done && empty && !eof_seen;
`endif

  assign push  = (state == REQ) && ack_s && !io_eof;
  assign serve = cpu_rd_req && !cpu_rd_done && (!empty || eof_seen);
  assign pop   = serve && !empty;

  // stage: ack synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= io_ack;
      ack_s    <= ack_meta;
    end
  end

  // stage: fetch handshake; IDLE waits for ack_s low so a stale ack after reset is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      io_req   <= 1'b0;
      eof_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!ack_s && fetch_want && !full) begin
            state  <= REQ;
            io_req <= 1'b1;
          end
        end
        REQ: begin
          if (ack_s) begin
            state  <= REL;
            io_req <= 1'b0;
            if (io_eof) eof_seen <= 1'b1;
          end
        end
        REL: begin
          if (!ack_s) state <= eof_seen ? DONE : IDLE;
        end
        DONE: begin
          io_req <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          io_req <= 1'b0;
        end
      endcase
    end
  end

  // stage: FIFO pointers and storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= io_data[7:0];
  end

  // stage: CPU read port; an empty FIFO past EOF answers -1 without popping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rd_done <= 1'b0;
      cpu_rd_data <= '0;
    end else begin
      cpu_rd_done <= serve;
      if (serve) cpu_rd_data <= empty ? '1 : {{(WORD_SIZE-8){1'b0}}, mem[rd_ptr[AW-1:0]]};
    end
  end

endmodule

// File: tb/tb_io_input_ctrl.sv
// Scoreboard bench for io_input_ctrl: a behavioural io_input source feeds bytes, expected CPU
// read results are queued as stimulus is issued and compared when cpu_rd_done pulses.
module tb_io_input_ctrl;

  localparam int DEPTH     = 4;
  localparam int WORD_SIZE = 16;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cpu_rd_req = 1'b0;
  logic                 cpu_rd_done;
  logic [WORD_SIZE-1:0] cpu_rd_data;
  logic                 io_req;
  logic                 io_ack = 1'b0;
  logic                 io_eof = 1'b0;
  logic [WORD_SIZE-1:0] io_data = '0;
  logic                 eof_seen;
  logic [LW-1:0]        level;

  always #5 clk = ~clk;

  io_input_ctrl #(.DEPTH(DEPTH), .WORD_SIZE(WORD_SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_rd_req(cpu_rd_req), .cpu_rd_done(cpu_rd_done),
    .cpu_rd_data(cpu_rd_data), .io_req(io_req), .io_ack(io_ack), .io_eof(io_eof),
    .io_data(io_data), .eof_seen(eof_seen), .level(level)
  );

  typedef struct packed {logic eof; logic [7:0] b;} src_t;

  src_t        src_q[$];
  logic [15:0] exp_q[$];
  src_t        cur;
  bit          hold_ack = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          ack_low_cnt = 0;
  logic        req_prev = 1'b0;
  int          max_level = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // behavioural io_input: four-phase handshake, junk on upper data bits and while ack is low
  initial begin
    forever begin
      @(posedge clk);
      if (io_req && !io_ack && src_q.size() > 0) begin
        #2;
        cur     = src_q.pop_front();
        io_data = {8'hA5, cur.b};
        io_eof  = cur.eof;
        io_ack  = 1'b1;
      end else if (io_ack && !io_req && !hold_ack) begin
        #2;
        io_ack  = 1'b0;
        io_data = 16'($urandom);
        io_eof  = 1'($urandom);
      end
    end
  end

  // monitors: scoreboard on done, ack-low guard on each new request, peak FIFO level
  initial begin
    forever begin
      @(negedge clk);
      ack_low_cnt = io_ack ? 0 : ack_low_cnt + 1;
      if (io_req && !req_prev) check("req_after_ack_low", 32'(ack_low_cnt >= 3), 32'd1);
      req_prev = io_req;
      if (int'(level) > max_level) max_level = int'(level);
      if (rst_n && cpu_rd_done) begin
        if (exp_q.size() == 0) check("unexpected_done", 32'(cpu_rd_data), 32'hDEAD);
        else check("rd_data", 32'(cpu_rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic push_byte(input logic eof, input logic [7:0] b);
    src_q.push_back({eof, b});
    if (!eof) exp_q.push_back({8'h00, b});
    else exp_q.push_back(16'hFFFF);
  endtask

  task automatic do_read(input int budget, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    cpu_rd_req = 1'b1;
    while (!cpu_rd_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_rd_done) check("rd_timeout", 32'd0, 32'd1);
    lat = n;
    cpu_rd_req = 1'b0;
  endtask

  task automatic wait_level(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (int'(level) != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(level), 32'(target));
  endtask

  int          lat;
  int          n;
  logic [7:0]  pat;
  logic        req_any;
  logic [7:0]  rb;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_io_req", 32'(io_req), 32'd0);
    check("rst_done", 32'(cpu_rd_done), 32'd0);
    check("rst_data", 32'(cpu_rd_data), 32'd0);
    check("rst_eof_seen", 32'(eof_seen), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    rst_n = 1'b1;

    // reset while the source holds ack high in the middle of a handshake
    src_q.push_back({1'b0, 8'h99});
    hold_ack = 1'b1;
`ifndef IO_INPUT_PREFETCH_EN
    cpu_rd_req = 1'b1;
`endif
    n = 0;
    while (!io_ack && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_ack_seen", 32'(io_ack), 32'd1);
    rst_n = 1'b0;
    cpu_rd_req = 1'b0;
    #1;
    check("mid_rst_io_req", 32'(io_req), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("stale_ack_no_req", 32'(io_req), 32'd0);
    check("stale_ack_level", 32'(level), 32'd0);
    hold_ack = 1'b0;
    repeat (6) @(negedge clk);

`ifdef IO_INPUT_PREFETCH_EN
    // prefetch fills the FIFO with no CPU demand
    for (int i = 0; i < 5; i++) push_byte(1'b0, 8'(8'h41 + i));
    wait_level(4, 300, "fill_level");
    repeat (10) @(negedge clk);
    check("full_level", 32'(level), 32'd4);
    check("full_no_req", 32'(io_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      do_read(20, lat);
      check("rd_latency", 32'(lat), 32'd1);
    end
    do_read(300, lat);
    wait_level(0, 50, "drained");

    // request held high with a full FIFO
    for (int i = 0; i < 4; i++) push_byte(1'b0, 8'(8'hB0 + i));
    wait_level(4, 300, "refill_level");
    repeat (4) @(negedge clk);
    cpu_rd_req = 1'b1;
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat[i] = cpu_rd_done;
    end
    cpu_rd_req = 1'b0;
    check("burst_pattern", 32'(pat), 32'h55);

    // push and pop on the same edge at level 2
    push_byte(1'b0, 8'hC1);
    push_byte(1'b0, 8'hC2);
    wait_level(2, 300, "coin_fill");
    repeat (3) @(negedge clk);
    push_byte(1'b0, 8'hC3);
    n = 0;
    while (!io_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("coin_ack", 32'(io_ack), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("coin_level_pre", 32'(level), 32'd2);
    cpu_rd_req = 1'b1;
    @(negedge clk);
    check("coin_done", 32'(cpu_rd_done), 32'd1);
    check("coin_level", 32'(level), 32'd2);
    cpu_rd_req = 1'b0;
    do_read(300, lat);
    do_read(300, lat);
`else
    // demand-only fetch
    push_byte(1'b0, 8'h7F);
    repeat (8) @(negedge clk);
    check("np_no_req_idle", 32'(io_req), 32'd0);
    do_read(300, lat);
    check("np_lat_handshake", 32'(lat > 1), 32'd1);
`endif

    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom);
      push_byte(1'b0, rb);
    end
    for (int i = 0; i < 10; i++) begin
      do_read(300, lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // end of file: one byte, then EOF; later reads return -1
    push_byte(1'b0, 8'h0A);
    push_byte(1'b1, 8'h55);
    exp_q.push_back(16'hFFFF);
    for (int i = 0; i < 3; i++) do_read(300, lat);
    check("eof_seen", 32'(eof_seen), 32'd1);
    check("eof_level", 32'(level), 32'd0);
    check("eof_src_consumed", 32'(src_q.size()), 32'd0);
    req_any = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_any = req_any | io_req;
    end
    check("done_no_req", 32'(req_any), 32'd0);

`ifdef IO_INPUT_PREFETCH_EN
    check("max_level", 32'(max_level), 32'd4);
`else
    check("max_level_le1", 32'(max_level <= 1), 32'd1);
`endif
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_input_ctrl.md
# io_input_ctrl

Synthesizable sequencer between the SUBLEQ CPU's input port and the `io_input` byte source. Drives the source's four-phase `req`/`ack` handshake, synchronizes `ack`, and buffers fetched bytes in a small FIFO. Handles end-of-file and serves CPU reads through a request/done handshake. On EOF the CPU receives all-ones (−1).

## Interface
- `DEPTH`, 4: FIFO entries. Power of two, ≥2.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_rd_req`  in  1  level; CPU wants one input word; held until `cpu_rd_done`.
- `cpu_rd_done`  out  1  one-cycle pulse; `cpu_rd_data` is valid in this cycle.
- `cpu_rd_data`  out  `WORD_SIZE`  zero-extended byte, or all-ones at EOF.
- `io_req`  out  1  request to `io_input`.
- `io_ack`  in  1  acknowledge from `io_input`; asynchronous to `clk`.
- `io_eof`  in  1  EOF flag from `io_input`; stable while `io_ack`=1.
- `io_data`  in  `WORD_SIZE`  byte from `io_input`; bits [7:0] used; stable while `io_ack`=1.
- `eof_seen`  out  1  sticky; source reported EOF.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- `io_ack` passes through a 2-flop synchronizer; `ack_s` is its output. All FSM decisions use `ack_s`.
- Fetch FSM states:
  - IDLE: `io_req`=0. Go to REQ when `ack_s`=0, `eof_seen`=0, and a fetch is wanted (see Configuration).
  - REQ: `io_req`=1. When `ack_s`=1, capture `io_eof`/`io_data[7:0]`, then go to REL.
  - REL: `io_req`=0. When `ack_s`=0, go to IDLE, or DONE if `eof_seen`.
  - DONE: terminal; `io_req`=0 until reset.
- Capture with `io_eof`=0: push the byte into the FIFO.
- Capture with `io_eof`=1: discard the data byte and set `eof_seen`.
- A FIFO slot is reserved on REQ entry, so a push never overflows. Entry to REQ requires `level` < DEPTH.
- CPU read: a read is served in cycle N when `cpu_rd_req`=1, `cpu_rd_done`=0 in cycle N, and one of these holds:
  - FIFO non-empty: pop the head. `cpu_rd_data` = {zeros, byte}.
  - FIFO empty and `eof_seen`: `cpu_rd_data` = all-ones. Nothing is popped, so every later read also returns −1.
- Otherwise the read waits; `cpu_rd_req` must stay high.
- A push and a pop in the same cycle are both performed; `level` is unchanged.
- FIFO pointers carry one extra wrap bit. Full = same index, different wrap bit. Empty = equal pointers.

## Timing
- Reset values:
  - `io_req`=0, `cpu_rd_done`=0, `cpu_rd_data`=0.
  - `eof_seen`=0, `level`=0, FSM=IDLE, pointers=0.
  - Synchronizer flops = 0.
- Read latency, data available: request seen in cycle N → `cpu_rd_done` in N+1.
  - `cpu_rd_req` is ignored in any cycle with `cpu_rd_done`=1, so the maximum rate is one read per 2 cycles.
- Fetch latency: REQ entry → capture takes ≥2 cycles after `io_ack` rises (synchronizer). The pushed byte is visible in `level` on the following edge.
- Reset mid-handshake: `io_req` drops immediately.
  - After reset, IDLE waits for `ack_s`=0 before a new REQ, so a stale `ack` is never taken as a new byte.
- `cpu_rd_data` holds its last value between `done` pulses.

## Configuration
- `IO_INPUT_PREFETCH_EN` defined: a fetch is wanted whenever `level` < DEPTH and `eof_seen`=0. The FIFO fills ahead of CPU demand.
- `IO_INPUT_PREFETCH_EN` undefined: a fetch is wanted only when `cpu_rd_req`=1 and the FIFO is empty. DEPTH storage is still instantiated, but `level` never exceeds 1.
  - Read latency then includes the full handshake.

## Test plan
- Reset while in REQ with a model holding `ack`=1 → `io_req`=0 at once. No new REQ until `ack` has been low ≥2 cycles. `level`=0.
- Prefetch on, source bytes 0x41, 0x42, 0x43, 0x44, 0x45, no CPU reads → `level` reaches 4 and `io_req` stays 0. Four reads then return 0x41–0x44 with `done` one cycle after each accepted request. The fifth fetch follows and yields 0x45.
- Source delivers 0x0A, then EOF (eof=1, data 0x55) → reads return 0x0A, then all-ones twice. `eof_seen`=1, FSM in DONE, 0x55 never delivered.
- Push and pop coincident at `level`=2 → `level` stays 2 and FIFO order is preserved. Ten random bytes match in order.
- `cpu_rd_req` held high continuously with a full FIFO → `done` pulses every other cycle, 4 pulses for 4 bytes.
- Prefetch off → `io_req` rises only after `cpu_rd_req`. `level` ≤1 throughout. Byte 0x7F is returned as {zeros, 0x7F}.
